// File: rtl/imem_boot_ctrl.sv
// Boot controller for the instruction memory.
// Gathers loader bytes into 32-bit words, writes them to the
// instruction memory, then hands the memory read port to the core.
// The core is held in stall and fed NOPs until the image is loaded.
module imem_boot_ctrl #(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter logic [31:0] NOP_INSTR   = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ld_valid,
  input  logic [7:0]  ld_byte,
  input  logic        ld_last,
  output logic        ld_ready,
  input  logic [31:0] fetch_addr,
  output logic [31:0] fetch_instr,
  output logic        core_stall,
  output logic        boot_done,
  output logic        load_err,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  // The word counter must be able to hold DEPTH_WORDS itself.
  localparam int unsigned CW          = $clog2(DEPTH_WORDS + 1);
  localparam logic [32:0] FETCH_LIMIT = 33'(DEPTH_WORDS) << 2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    FLUSH = 3'd2,
    RUN   = 3'd3,
    ERROR = 3'd4
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [1:0]      byte_idx;
  logic [CW-1:0]   word_count;
  logic [31:0]     asm_word;
  logic            wr_pend;

  logic            accept;
  logic            overflow;
  logic            take_byte;
  logic            wr_set;
  logic [CW:0]     words_used;
  logic [31:0]     word_addr;

  // Byte acceptance, overflow detection and next-state selection.
  // A write that is pending this cycle already owns word_count, so a new
  // word would start at word_count + wr_pend.
  always_comb begin
    ld_ready   = (state == IDLE) || (state == LOAD);
    accept     = ld_valid && ld_ready;
    words_used = {1'b0, word_count} + {{CW{1'b0}}, wr_pend};
    overflow   = accept && (byte_idx == 2'd0) &&
                 (words_used == (CW+1)'(DEPTH_WORDS));
    take_byte  = accept && !overflow;
    wr_set     = take_byte && (byte_idx == 2'd3) && !ld_last;
    word_addr  = {{(30-CW){1'b0}}, word_count, 2'b00};
    state_next = state;
    case (state)
      IDLE, LOAD: begin
        if (accept) begin
          if (overflow)     state_next = ERROR;
          else if (ld_last) state_next = FLUSH;
          else              state_next = LOAD;
        end
      end
      FLUSH:   state_next = RUN;
      RUN:     state_next = RUN;
      ERROR:   state_next = ERROR;
      default: state_next = IDLE;
    endcase
  end

  // Output decode: memory write port while loading, read path in RUN.
  always_comb begin
    core_stall  = 1'b1;
    boot_done   = 1'b0;
    load_err    = (state == ERROR);
    mem_we      = 1'b0;
    mem_addr    = 32'h0;
    mem_wdata   = 32'h0;
    fetch_instr = NOP_INSTR;
    case (state)
      IDLE, LOAD: begin
        if (wr_pend) begin
          mem_we    = 1'b1;
          mem_addr  = word_addr;
          mem_wdata = asm_word;
        end
      end
      FLUSH: begin
        mem_we    = 1'b1;
        mem_addr  = word_addr;
        mem_wdata = asm_word;
      end
      RUN: begin
        core_stall = 1'b0;
        boot_done  = 1'b1;
        mem_addr   = fetch_addr;
        if ({1'b0, fetch_addr} < FETCH_LIMIT) fetch_instr = mem_rdata;
      end
      default: ;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Word assembly, write scheduling and word counting; byte 0 of a word
  // clears the upper lanes so a short final word is zero-padded.
  always_ff @(posedge clk) begin
    if (rst) begin
      byte_idx   <= 2'd0;
      word_count <= '0;
      asm_word   <= 32'h0;
      wr_pend    <= 1'b0;
    end else begin
      wr_pend <= wr_set;
      if (wr_pend) word_count <= word_count + CW'(1);
      if (take_byte) begin
        byte_idx <= byte_idx + 2'd1;
        if (byte_idx == 2'd0) asm_word <= {24'h0, ld_byte};
        else                  asm_word[{byte_idx, 3'b000} +: 8] <= ld_byte;
      end
    end
  end

endmodule
